// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect generation for a 5-stage core.
// Ports: clk, rst (sync, active-high); if/id/mem stall requests; EX branch
//   taken + target in; stall[5:0] hold enables, flush_if_id, flush_id_ex,
//   pc_redirect + pc_redirect_addr out; stall_cycles saturating stall counter.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req,
    input  logic              id_stall_req,
    input  logic              mem_stall_req,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic [5:0]        stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_redirect_addr,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {
        RUN,
        WAIT_IF
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_PC   = 6'b000001;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] tgt_q;
    logic              tgt_load;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_sat;

    assign cnt_sat      = &cnt_q;
    assign stall_cycles = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            tgt_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            if (tgt_load) begin
                tgt_q <= ex_branch_target;
            end
            if (stall[0] && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Priority: reset, then a MEM stall freezes everything (including a
    // branch sitting in EX, which re-presents once MEM releases), then the
    // pending-redirect / branch handling, then ID and IF stalls.
    always_comb begin
        state_next       = state;
        tgt_load         = 1'b0;
        stall            = STALL_NONE;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = '0;

        if (rst) begin
            state_next = RUN;
        end else if (mem_stall_req) begin
            stall = STALL_MEM;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (if_stall_req) begin
                            // Fetch still in flight: hold PC, remember target.
                            stall      = STALL_PC;
                            tgt_load   = 1'b1;
                            state_next = WAIT_IF;
                        end else begin
                            pc_redirect      = 1'b1;
                            pc_redirect_addr = ex_branch_target;
                        end
                    end else if (id_stall_req) begin
                        stall       = STALL_ID;
                        flush_id_ex = 1'b1;
                    end else if (if_stall_req) begin
                        stall = STALL_IF;
                    end
                end
                WAIT_IF: begin
                    // EX holds only bubbles here, so any branch input is stale.
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (if_stall_req) begin
                        stall = STALL_PC;
                    end else begin
                        pc_redirect      = 1'b1;
                        pc_redirect_addr = tgt_q;
                        state_next       = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: rule-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        mem_stall_req;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [5:0]  stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic [31:0] stall_cycles;
    logic [5:0]  s_stall;
    logic        s_fif;
    logic        s_fex;
    logic        s_red;
    logic [31:0] s_addr;
    logic [3:0]  s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    bit go     = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .mem_stall_req(mem_stall_req), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
        .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .mem_stall_req(mem_stall_req), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .stall(s_stall), .flush_if_id(s_fif), .flush_id_ex(s_fex),
        .pc_redirect(s_red), .pc_redirect_addr(s_addr),
        .stall_cycles(s_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model: a branch is "pending" once accepted while fetch was busy;
    // the stall count is a plain integer clamped at read time for CNT_W=4.
    bit          m_pend = 1'b0;
    logic [31:0] m_tgt  = '0;
    int          m_cnt  = 0;

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_fif, e_fex, e_red;
        logic [31:0] e_addr;
        e_stall = '0; e_fif = 0; e_fex = 0; e_red = 0; e_addr = '0;
        if (rst) begin
        end else if (mem_stall_req) begin
            e_stall = 6'b011111;
        end else if (m_pend || ex_branch_taken) begin
            e_fif = 1; e_fex = 1;
            if (if_stall_req) e_stall = 6'b000001;
            else begin
                e_red  = 1;
                e_addr = m_pend ? m_tgt : ex_branch_target;
            end
        end else if (id_stall_req) begin
            e_stall = 6'b000111; e_fex = 1;
        end else if (if_stall_req) begin
            e_stall = 6'b000011;
        end
        if (go) begin
            check("stall", 64'(stall), 64'(e_stall));
            check("flush_if_id", 64'(flush_if_id), 64'(e_fif));
            check("flush_id_ex", 64'(flush_id_ex), 64'(e_fex));
            check("pc_redirect", 64'(pc_redirect), 64'(e_red));
            check("redirect_addr", 64'(pc_redirect_addr), 64'(e_addr));
            check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
            check("stall_cycles4", 64'(s_cnt), 64'(m_cnt > 15 ? 15 : m_cnt));
            check("redirect_vs_stall", 64'(pc_redirect & stall[0]), 64'(0));
        end
        if (rst) begin
            m_pend = 0; m_tgt = '0; m_cnt = 0;
        end else begin
            if (!mem_stall_req) begin
                if (m_pend && !if_stall_req) m_pend = 0;
                else if (!m_pend && ex_branch_taken && if_stall_req) begin
                    m_pend = 1; m_tgt = ex_branch_target;
                end
            end
            if (e_stall[0]) m_cnt++;
        end
    end

    task automatic drive(input logic r, input logic i_s, input logic d_s,
                         input logic m_s, input logic br,
                         input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; if_stall_req = i_s; id_stall_req = d_s;
        mem_stall_req = m_s; ex_branch_taken = br; ex_branch_target = t;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic reset();
        drive(1, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1; if_stall_req = 0; id_stall_req = 0; mem_stall_req = 0;
        ex_branch_taken = 0; ex_branch_target = '0;
        @(posedge clk);
        #1 go = 1;

        // Reset with every input high: outputs must stay 0.
        drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_redirect", 64'(pc_redirect), 64'h0);
        check("rst_flush", 64'({flush_if_id, flush_id_ex}), 64'h0);
        idle();
        check("rst_cnt", 64'(stall_cycles), 64'h0);

        // Plain taken branch.
        reset();
        drive(0, 0, 1, 0, 1, 32'h100);
        check("br_redirect", 64'(pc_redirect), 64'h1);
        check("br_addr", 64'(pc_redirect_addr), 64'h100);
        check("br_flush", 64'({flush_if_id, flush_id_ex}), 64'h3);
        check("br_stall", 64'(stall), 64'h0);

        // Branch while fetch busy for 3 cycles.
        reset();
        drive(0, 1, 0, 0, 1, 32'h200);
        check("wif_stall0", 64'(stall), 64'h01);
        check("wif_flush0", 64'({flush_if_id, flush_id_ex}), 64'h3);
        drive(0, 1, 0, 0, 1, 32'hDEAD);
        check("wif_stall1", 64'(stall), 64'h01);
        check("wif_red1", 64'(pc_redirect), 64'h0);
        drive(0, 1, 0, 0, 0, 32'hBEEF);
        check("wif_stall2", 64'(stall), 64'h01);
        drive(0, 0, 0, 0, 0, 32'hBEEF);
        check("wif_red", 64'(pc_redirect), 64'h1);
        check("wif_addr", 64'(pc_redirect_addr), 64'h200);
        check("wif_cnt", 64'(stall_cycles), 64'h3);
        idle();
        check("wif_once", 64'(pc_redirect), 64'h0);

        // MEM stall freezes a branch and an ID stall.
        reset();
        drive(0, 0, 1, 1, 1, 32'h400);
        check("mem_stall", 64'(stall), 64'h1F);
        check("mem_noflush", 64'({flush_if_id, flush_id_ex}), 64'h0);
        check("mem_nored", 64'(pc_redirect), 64'h0);
        drive(0, 0, 1, 0, 1, 32'h400);
        check("mem_rel_red", 64'(pc_redirect), 64'h1);
        check("mem_rel_addr", 64'(pc_redirect_addr), 64'h400);

        // Load-use stall for 2 cycles.
        reset();
        drive(0, 0, 1, 0, 0, 32'h0);
        check("id_stall0", 64'(stall), 64'h07);
        check("id_fex0", 64'(flush_id_ex), 64'h1);
        drive(0, 0, 1, 0, 0, 32'h0);
        check("id_stall1", 64'(stall), 64'h07);
        idle();
        check("id_cnt", 64'(stall_cycles), 64'h2);

        // Reset while waiting drops the pending redirect.
        reset();
        drive(0, 1, 0, 0, 1, 32'h300);
        drive(1, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rstw_nored", 64'(pc_redirect), 64'h0);
        check("rstw_cnt", 64'(stall_cycles), 64'h0);

        // MEM stall inside WAIT_IF, then release.
        reset();
        drive(0, 1, 0, 0, 1, 32'h500);
        drive(0, 1, 0, 1, 1, 32'h600);
        check("wm_stall", 64'(stall), 64'h1F);
        check("wm_flush", 64'({flush_if_id, flush_id_ex}), 64'h0);
        drive(0, 0, 1, 0, 1, 32'h700);
        check("wm_addr", 64'(pc_redirect_addr), 64'h500);
        idle();

        // Saturation of the narrow counter.
        reset();
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 32'h0);
        check("if_stall", 64'(stall), 64'h03);
        idle();
        check("sat4", 64'(s_cnt), 64'hF);
        check("cnt20", 64'(stall_cycles), 64'd20);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
